// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
//   Shared definitions for the AHB-lite to APB2 bridge:
//     - AHB transfer-type and response encodings
//     - APB state machine state enum
//     - slave address windows (base/limit) and one-hot select encodings
//     - helper to recognise transfers that carry a request (NONSEQ/SEQ)
// -----------------------------------------------------------------------------
package bridge_pkg;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB response; the bridge never signals anything but OKAY
    localparam logic [1:0] HRESP_OKAY    = 2'b00;

    // APB access state machine
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ENABLE = 2'b10
    } apb_state_e;

    // Number of APB slaves behind the bridge
    localparam int NUM_SLV = 3;

    // Address windows, index i drives Pselx[i]. Windows are inclusive.
    localparam logic [NUM_SLV-1:0][31:0] SLV_BASE = {
        32'h8800_0000,
        32'h8400_0000,
        32'h8000_0000
    };
    localparam logic [NUM_SLV-1:0][31:0] SLV_LIMIT = {
        32'h8BFF_FFFF,
        32'h87FF_FFFF,
        32'h83FF_FFFF
    };

    // One-hot select encodings
    localparam logic [NUM_SLV-1:0] SEL_NONE = 3'b000;
    localparam logic [NUM_SLV-1:0] SEL_S0   = 3'b001;
    localparam logic [NUM_SLV-1:0] SEL_S1   = 3'b010;
    localparam logic [NUM_SLV-1:0] SEL_S2   = 3'b100;

    // A transfer carries a request only when it is NONSEQ or SEQ.
    function automatic logic is_active_trans(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/bridge_apb_fsm.sv
// -----------------------------------------------------------------------------
// bridge_apb_fsm
//   APB2 master state machine. A one-cycle 'start' pulse in IDLE launches a
//   fixed two-cycle SETUP/ENABLE access; ENABLE always returns to IDLE since
//   APB2 has no wait states. All APB outputs come straight from flops.
//
// Ports
//   clk        in   clock
//   rst_n      in   synchronous reset, active low
//   start      in   launch an access (only honoured in IDLE)
//   addr       in   access address, captured on launch
//   write      in   access direction, captured on launch
//   sel        in   one-hot slave select, captured on launch
//   wdata      in   write data, captured on launch of a write
//   fsm_idle   out  state machine is IDLE
//   fsm_enable out  state machine is in the ENABLE cycle
//   pselx      out  one-hot APB select (zero in IDLE)
//   paddr      out  APB address (holds last value in IDLE)
//   pwrite     out  APB direction (holds last value in IDLE)
//   penable    out  APB enable
//   pwdata     out  APB write data (holds last value in IDLE and for reads)
// -----------------------------------------------------------------------------
module bridge_apb_fsm
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               write,
    input  logic [NUM_SLV-1:0] sel,
    input  logic [DATA_W-1:0]  wdata,
    output logic               fsm_idle,
    output logic               fsm_enable,
    output logic [NUM_SLV-1:0] pselx,
    output logic [ADDR_W-1:0]  paddr,
    output logic               pwrite,
    output logic               penable,
    output logic [DATA_W-1:0]  pwdata
);

    apb_state_e         state_q,   state_d;
    logic [NUM_SLV-1:0] pselx_q,   pselx_d;
    logic [ADDR_W-1:0]  paddr_q,   paddr_d;
    logic               pwrite_q,  pwrite_d;
    logic               penable_q, penable_d;
    logic [DATA_W-1:0]  pwdata_q,  pwdata_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pselx_q   <= SEL_NONE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            pselx_q   <= pselx_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            pwdata_q  <= pwdata_d;
        end
    end

    // Next-state and next-output logic. The outputs are computed one cycle
    // ahead so that in SETUP/ENABLE the registered P* signals already show
    // the access belonging to that state.
    always_comb begin
        state_d   = state_q;
        pselx_d   = pselx_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        penable_d = 1'b0;
        pwdata_d  = pwdata_q;

        unique case (state_q)
            ST_IDLE: begin
                pselx_d = SEL_NONE;
                if (start) begin
                    state_d  = ST_SETUP;
                    pselx_d  = sel;
                    paddr_d  = addr;
                    pwrite_d = write;
                    // Reads leave the write-data bus untouched.
                    if (write) begin
                        pwdata_d = wdata;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ENABLE;
                penable_d = 1'b1;
            end
            ST_ENABLE: begin
                state_d = ST_IDLE;
                pselx_d = SEL_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                pselx_d = SEL_NONE;
            end
        endcase
    end

    assign fsm_idle   = (state_q == ST_IDLE);
    assign fsm_enable = (state_q == ST_ENABLE);
    assign pselx      = pselx_q;
    assign paddr      = paddr_q;
    assign pwrite     = pwrite_q;
    assign penable    = penable_q;
    assign pwdata     = pwdata_q;

endmodule

// File: rtl/bridge_top.sv
// -----------------------------------------------------------------------------
// bridge_top
//   AHB-lite slave to APB2 master bridge, single clock. Holds one AHB request
//   (address phase result), decodes it to one of three APB slaves, runs one
//   APB SETUP/ENABLE access per request and stalls the AHB data phase with
//   Hreadyout while the APB side is busy. Writes are posted: the data phase
//   completes as soon as the APB access is launched. Reads complete in the
//   ENABLE cycle of their own access with Prdata passed straight through.
//
// Ports
//   Hclk       in   clock for both sides
//   Hresetn    in   synchronous reset, active low
//   Hwrite     in   AHB direction (address phase)
//   Hreadyin   in   AHB ready from fabric; gates acceptance
//   Htrans     in   AHB transfer type
//   Haddr      in   AHB address (address phase)
//   Hwdata     in   AHB write data (data phase)
//   Prdata     in   APB read data
//   Hreadyout  out  AHB ready; 0 inserts a wait state
//   Hresp      out  AHB response, always OKAY
//   Hrdata     out  AHB read data, zero outside a read ENABLE cycle
//   Pselx      out  one-hot APB select
//   Paddr      out  APB address
//   Pwrite     out  APB direction
//   Penable    out  APB enable
//   Pwdata     out  APB write data
// -----------------------------------------------------------------------------
module bridge_top
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic               Hwrite,
    input  logic               Hreadyin,
    input  logic [1:0]         Htrans,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [DATA_W-1:0]  Hwdata,
    input  logic [DATA_W-1:0]  Prdata,
    output logic               Hreadyout,
    output logic [1:0]         Hresp,
    output logic [DATA_W-1:0]  Hrdata,
    output logic [NUM_SLV-1:0] Pselx,
    output logic [ADDR_W-1:0]  Paddr,
    output logic               Pwrite,
    output logic               Penable,
    output logic [DATA_W-1:0]  Pwdata
);

    // -------------------------------------------------------------------------
    // Address decode: one comparator pair per slave window.
    // -------------------------------------------------------------------------
    logic [NUM_SLV-1:0] dec_sel;

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_dec
        assign dec_sel[gi] = (Haddr >= ADDR_W'(SLV_BASE[gi])) &&
                             (Haddr <= ADDR_W'(SLV_LIMIT[gi]));
    end

    // -------------------------------------------------------------------------
    // Request register: the transfer currently in its data phase.
    // -------------------------------------------------------------------------
    logic               req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]  req_addr_q,  req_addr_d;
    logic               req_write_q, req_write_d;
    logic [NUM_SLV-1:0] req_sel_q,   req_sel_d;

    logic fsm_idle;
    logic fsm_enable;
    logic accept;
    logic apb_start;

    // Data-phase ready.
    //   - no request in data phase: ready, so a new address can be taken
    //   - posted write or unmapped access: completes once the APB side is idle
    //   - mapped read: completes in the ENABLE cycle of its own access. While
    //     a read is pending nothing else can be launched, so any ENABLE cycle
    //     with Pwrite=0 must belong to it; an ENABLE of an earlier posted
    //     write (Pwrite=1) keeps the read waiting.
    always_comb begin
        Hreadyout = 1'b1;
        if (req_valid_q) begin
            if (req_write_q || (req_sel_q == SEL_NONE)) begin
                Hreadyout = fsm_idle;
            end else begin
                Hreadyout = fsm_enable && !Pwrite;
            end
        end
    end

    assign accept = Hreadyin && Hreadyout && is_active_trans(Htrans);

    // A completing data phase frees the register for the next address phase
    // in the same cycle; otherwise the request is held.
    always_comb begin
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_write_d = req_write_q;
        req_sel_d   = req_sel_q;
        if (Hreadyout) begin
            req_valid_d = accept;
            if (accept) begin
                req_addr_d  = Haddr;
                req_write_d = Hwrite;
                req_sel_d   = dec_sel;
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_sel_q   <= SEL_NONE;
        end else begin
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_write_q <= req_write_d;
            req_sel_q   <= req_sel_d;
        end
    end

    // Launch the APB access for a mapped request as soon as the APB side is
    // idle. For a write this is the completing data-phase cycle, so Hwdata is
    // valid here. For a read the request stays pending, and since the FSM
    // leaves IDLE immediately it is launched only once.
    assign apb_start = req_valid_q && (req_sel_q != SEL_NONE) && fsm_idle;

    bridge_apb_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_apb_fsm (
        .clk        (Hclk),
        .rst_n      (Hresetn),
        .start      (apb_start),
        .addr       (req_addr_q),
        .write      (req_write_q),
        .sel        (req_sel_q),
        .wdata      (Hwdata),
        .fsm_idle   (fsm_idle),
        .fsm_enable (fsm_enable),
        .pselx      (Pselx),
        .paddr      (Paddr),
        .pwrite     (Pwrite),
        .penable    (Penable),
        .pwdata     (Pwdata)
    );

    // Read data is forwarded combinationally only in a read ENABLE cycle.
    assign Hrdata = (fsm_enable && !Pwrite) ? Prdata : '0;
    assign Hresp  = HRESP_OKAY;

endmodule

// File: tb/tb_bridge_top.sv
// -----------------------------------------------------------------------------
// tb_bridge_top
//   Directed scenarios with literal expectations, then randomized AHB traffic.
//   A transaction-level model (pending request + remaining APB bus cycles)
//   predicts every output each cycle; one process compares at the negedge.
// -----------------------------------------------------------------------------
module tb_bridge_top;

    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b0;
    logic        Hwrite = 1'b0;
    logic        Hreadyin = 1'b1;
    logic [1:0]  Htrans = 2'b00;
    logic [31:0] Haddr = '0;
    logic [31:0] Hwdata = '0;
    logic [31:0] Prdata = '0;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic        Pwrite;
    logic        Penable;
    logic [31:0] Pwdata;

    always #5 Hclk = ~Hclk;

    bridge_top #(.ADDR_W(32), .DATA_W(32)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Prdata    (Prdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .Pselx     (Pselx),
        .Paddr     (Paddr),
        .Pwrite    (Pwrite),
        .Penable   (Penable),
        .Pwdata    (Pwdata)
    );

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // ---------------- behavioural model ----------------
    bit          m_pend;        // a request is in its data phase
    logic [31:0] m_pend_addr;
    bit          m_pend_write;
    logic [2:0]  m_pend_sel;
    logic [31:0] m_pend_wdata;  // data the bench master supplies for it
    int          m_busy;        // APB bus cycles left: 2=SETUP, 1=ENABLE, 0=idle
    logic [31:0] m_acc_addr;
    logic [31:0] m_acc_wdata;
    bit          m_acc_write;
    logic [2:0]  m_acc_sel;
    logic [31:0] addr_wdata;    // data for the transfer in the current address phase

    logic        e_ready;
    logic [31:0] e_hrdata;
    logic [2:0]  e_pselx;
    logic        e_penable;
    logic [31:0] e_paddr;
    logic        e_pwrite;
    logic [31:0] e_pwdata;

    // Each slave owns a 64 MiB window starting at 0x8000_0000.
    function automatic logic [2:0] region(input logic [31:0] a);
        case (a[31:26])
            6'h20:   return 3'b001;
            6'h21:   return 3'b010;
            6'h22:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Data phase completes: writes/unmapped when the APB bus is free,
    // reads in the last (ENABLE) cycle of their own access.
    function automatic logic model_ready();
        if (!m_pend) return 1'b1;
        if (m_pend_write || m_pend_sel == 3'b000) return (m_busy == 0);
        return (m_busy == 1) && !m_acc_write;
    endfunction

    task automatic model_step();
        bit rdy;
        bit acc;
        if (!Hresetn) begin
            m_pend = 0; m_pend_addr = '0; m_pend_write = 0; m_pend_sel = '0; m_pend_wdata = '0;
            m_busy = 0; m_acc_addr = '0; m_acc_wdata = '0; m_acc_write = 0; m_acc_sel = '0;
            return;
        end
        rdy = model_ready();
        acc = Hreadyin && rdy && Htrans[1];
        if (m_pend && m_pend_sel != 3'b000 && m_busy == 0) begin
            m_busy      = 2;
            m_acc_addr  = m_pend_addr;
            m_acc_write = m_pend_write;
            m_acc_sel   = m_pend_sel;
            if (m_pend_write) m_acc_wdata = Hwdata;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        if (rdy) begin
            m_pend = acc;
            if (acc) begin
                m_pend_addr  = Haddr;
                m_pend_write = Hwrite;
                m_pend_sel   = region(Haddr);
                m_pend_wdata = addr_wdata;
            end
        end
    endtask

    task automatic compute_expected();
        e_ready   = model_ready();
        e_pselx   = (m_busy != 0) ? m_acc_sel : 3'b000;
        e_penable = (m_busy == 1);
        e_paddr   = m_acc_addr;
        e_pwrite  = m_acc_write;
        e_pwdata  = m_acc_wdata;
        e_hrdata  = (m_busy == 1 && !m_acc_write) ? Prdata : 32'h0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: update model with the inputs seen at the edge, then drive
    // the next cycle's inputs. Hwdata follows the pending write's data.
    task automatic cycle(input bit rstn, input bit rdyin, input logic [1:0] tr,
                         input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] prd);
        @(posedge Hclk);
        #1;
        model_step();
        if (!Hresetn) check_en = 1'b1;
        Hresetn    = rstn;
        Hreadyin   = rdyin;
        Htrans     = tr;
        Hwrite     = wr;
        Haddr      = a;
        addr_wdata = wd;
        Prdata     = prd;
        Hwdata     = (m_pend && m_pend_write) ? m_pend_wdata : $urandom;
        compute_expected();
    endtask

    task automatic idle(input logic [31:0] prd);
        cycle(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0, prd);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 9))
            0: return 32'h8000_0000;
            1: return 32'h83FF_FFFF;
            2: return 32'h8400_0000;
            3: return 32'h87FF_FFFF;
            4: return 32'h8800_0000;
            5: return 32'h8BFF_FFFF;
            6: return 32'h8C00_0000;
            7: return 32'h7FFF_FFFF;
            8: return 32'h8000_0000 | 32'($urandom_range(0, 32'h0BFF_FFFF));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge Hclk);
            if (check_en) begin
                chk("hreadyout", 32'(Hreadyout), 32'(e_ready));
                chk("hresp",     32'(Hresp),     32'h0);
                chk("hrdata",    Hrdata,         e_hrdata);
                chk("pselx",     32'(Pselx),     32'(e_pselx));
                chk("penable",   32'(Penable),   32'(e_penable));
                chk("paddr",     Paddr,          e_paddr);
                chk("pwrite",    32'(Pwrite),    32'(e_pwrite));
                chk("pwdata",    Pwdata,         e_pwdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // 1. reset for two edges
        cycle(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        idle(32'h0);
        #1;
        chk("rst_pselx",   32'(Pselx),     32'h0);
        chk("rst_penable", 32'(Penable),   32'h0);
        chk("rst_ready",   32'(Hreadyout), 32'h1);
        chk("rst_hresp",   32'(Hresp),     32'h0);
        chk("rst_hrdata",  Hrdata,         32'h0);

        // 2. single write
        cycle(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0004, 32'hA5A5_5A5A, 32'h0);
        idle(32'h0); #1;
        chk("w1_ready", 32'(Hreadyout), 32'h1);
        idle(32'h0); #1;
        chk("w1_setup_psel",  32'(Pselx),   32'h1);
        chk("w1_setup_pen",   32'(Penable), 32'h0);
        chk("w1_setup_paddr", Paddr,        32'h8000_0004);
        chk("w1_setup_pwd",   Pwdata,       32'hA5A5_5A5A);
        chk("w1_setup_pwr",   32'(Pwrite),  32'h1);
        idle(32'h0); #1;
        chk("w1_enable_pen",  32'(Penable), 32'h1);
        idle(32'h0); #1;
        chk("w1_idle_psel",   32'(Pselx),   32'h0);

        // 3. back-to-back writes
        cycle(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0004, 32'h0BAD_F00D, 32'h0);
        cycle(1'b1, 1'b1, 2'b11, 1'b1, 32'h8000_00FF, 32'hDEAD_DEAD, 32'h0); #1;
        chk("b2b_ready_dp1", 32'(Hreadyout), 32'h1);
        idle(32'h0); #1;
        chk("b2b_wait1", 32'(Hreadyout), 32'h0);
        idle(32'h0); #1;
        chk("b2b_wait2", 32'(Hreadyout), 32'h0);
        idle(32'h0); #1;
        chk("b2b_done", 32'(Hreadyout), 32'h1);
        idle(32'h0); #1;
        chk("b2b_paddr", Paddr,  32'h8000_00FF);
        chk("b2b_pwd",   Pwdata, 32'hDEAD_DEAD);
        idle(32'h0);
        idle(32'h0);

        // 4. read from slave 1
        cycle(1'b1, 1'b1, 2'b10, 1'b0, 32'h8400_0010, 32'h0, 32'h1234_5678);
        idle(32'h1234_5678); #1;
        chk("rd_wait1", 32'(Hreadyout), 32'h0);
        idle(32'h1234_5678); #1;
        chk("rd_wait2", 32'(Hreadyout), 32'h0);
        chk("rd_psel",  32'(Pselx),     32'h2);
        chk("rd_pwr",   32'(Pwrite),    32'h0);
        idle(32'h1234_5678); #1;
        chk("rd_ready", 32'(Hreadyout), 32'h1);
        chk("rd_data",  Hrdata,         32'h1234_5678);
        idle(32'h1234_5678); #1;
        chk("rd_after_data", Hrdata, 32'h0);

        // 5. write to slave 2, then unmapped read
        cycle(1'b1, 1'b1, 2'b10, 1'b1, 32'h8800_0000, 32'h1111_2222, 32'h0);
        idle(32'h0);
        idle(32'h0); #1;
        chk("s2_psel", 32'(Pselx), 32'h4);
        idle(32'h0);
        idle(32'h0);
        cycle(1'b1, 1'b1, 2'b10, 1'b0, 32'h9000_0000, 32'h0, 32'hFFFF_FFFF);
        idle(32'hFFFF_FFFF); #1;
        chk("unm_ready",  32'(Hreadyout), 32'h1);
        chk("unm_hrdata", Hrdata,         32'h0);
        chk("unm_psel",   32'(Pselx),     32'h0);

        // 6. BUSY, IDLE and Hreadyin=0 accept nothing
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 32'h8000_0000, 32'h0, 32'h0);
        cycle(1'b1, 1'b1, 2'b00, 1'b1, 32'h8400_0000, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 2'b10, 1'b1, 32'h8800_0000, 32'h0, 32'h0); #1;
        chk("nop_ready1", 32'(Hreadyout), 32'h1);
        idle(32'h0); #1;
        chk("nop_ready2", 32'(Hreadyout), 32'h1);
        chk("nop_psel",   32'(Pselx),     32'h0);
        idle(32'h0); #1;
        chk("nop_psel2",  32'(Pselx),     32'h0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit          rstn;
            bit          rdyin;
            logic [1:0]  tr;
            bit          wr;
            rstn  = ($urandom_range(0, 199) != 0);
            rdyin = ($urandom_range(0, 6) != 0);
            tr    = 2'($urandom_range(0, 3));
            wr    = 1'($urandom_range(0, 1));
            cycle(rstn, rdyin, tr, wr, pick_addr(), $urandom, $urandom);
        end
        for (int i = 0; i < 8; i++) idle($urandom);

        @(posedge Hclk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
